// File: rtl/cam_init_seq.sv
// cam_init_seq: camera bring-up sequencer (cam_clk domain).
// Releases sensor power-down, then pulses the hardware reset, then walks a
// register table and issues each entry to the SCCB master through a level
// start/busy handshake.
// Build option: define CAM_INIT_RETRY_EN to retry timed-out handshakes
// (up to 3 per entry) and to add the retry_cnt output.
module cam_init_seq #(
  parameter int PWDN_CYCLES    = 4096,
  parameter int RST_CYCLES     = 524288,
  parameter int SETTLE_CYCLES  = 65536,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              cam_clk,
  input  logic              rstn,
  input  logic              dbun,
  output logic [ADDR_W-1:0] cfg_addr,
  input  logic [23:0]       cfg_data,
  output logic              sccb_start,
  output logic [1:0]        sccb_wr,
  output logic [31:0]       sccb_data,
  input  logic              sccb_busy,
  output logic              cam_pwdn,
  output logic              cam_rstn,
  output logic              init_done,
  output logic              init_err,
`ifdef CAM_INIT_RETRY_EN
  output logic [1:0]        retry_cnt,
`endif
  output logic [ADDR_W:0]   reg_count
);

  // 21 bits covers TIMEOUT_CYCLES-1 and the largest delay entry (255*1024)
  localparam int CNT_W = 21;

`ifdef CAM_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_PWDN, S_RST, S_SETTLE, S_FETCH, S_DECODE, S_DELAY,
    S_REQ, S_WAIT, S_RWAIT, S_DONE, S_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         busy_sync;
  logic               busy;
  logic [1:0]         retry_q;
  logic               last;
  logic               adv, wr_inc, latch, retry_inc, retry_clr, can_retry;
  logic               pwdn_nxt, crstn_nxt, start_nxt, done_nxt, err_nxt;

  assign busy      = busy_sync[1];
  assign last      = (cfg_addr == {ADDR_W{1'b1}});
  assign can_retry = RETRY_EN && (retry_q != 2'd3);

`ifdef CAM_INIT_RETRY_EN
  assign retry_cnt = retry_q;
`endif

  // two-flop synchronizer for the SCCB master's busy level
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) busy_sync <= 2'b00;
    else       busy_sync <= {busy_sync[0], sccb_busy};
  end

  // state register and shared down-counter
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_PWDN;
      cnt   <= CNT_W'(PWDN_CYCLES - 1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next-state, counter and table-walk control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 1'b1;
    adv       = 1'b0;
    wr_inc    = 1'b0;
    latch     = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state)
      S_PWDN:
        if (cnt == '0) begin
          state_nxt = S_RST;
          cnt_nxt   = CNT_W'(RST_CYCLES - 1);
        end
      S_RST:
        if (cnt == '0) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end
      S_SETTLE:
        if (cnt == '0) state_nxt = S_FETCH;
      S_FETCH:
        state_nxt = S_DECODE;
      S_DECODE: begin
        cnt_nxt = cnt;
        if (cfg_data == 24'hFFFFFF) begin
          state_nxt = S_DONE;
        end else if (cfg_data[23:8] == 16'hFFF0) begin
          state_nxt = S_DELAY;
          cnt_nxt   = CNT_W'({cfg_data[7:0], 10'b0});
        end else begin
          state_nxt = S_REQ;
          latch     = 1'b1;
          retry_clr = 1'b1;
          cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
        end
      end
      // leaves 2 cycles early so successive fetches are value*1024 apart
      // (the next FETCH/DECODE pair makes up the difference)
      S_DELAY:
        if (cnt <= CNT_W'(3)) begin
          state_nxt = last ? S_DONE : S_FETCH;
          adv       = 1'b1;
        end
      S_REQ, S_WAIT: begin
        if ((state == S_REQ) ? busy : !busy) begin
          state_nxt = (state == S_REQ) ? S_WAIT : (last ? S_DONE : S_FETCH);
          cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
          adv       = (state == S_WAIT);
          wr_inc    = (state == S_WAIT);
        end else if (cnt == '0) begin
          cnt_nxt = CNT_W'(TIMEOUT_CYCLES - 1);
          if (can_retry) begin
            state_nxt = S_RWAIT;
            retry_inc = 1'b1;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      // start dropped after a timeout; wait for the master to go idle
      S_RWAIT:
        if (!busy) begin
          state_nxt = S_REQ;
          cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (cnt == '0) begin
          state_nxt = S_ERR;
        end
      S_DONE, S_ERR: cnt_nxt = cnt;
      default:       state_nxt = S_PWDN;
    endcase
    // power-down request overrides everything, abandoning any transaction
    if (dbun) begin
      state_nxt = S_PWDN;
      cnt_nxt   = CNT_W'(PWDN_CYCLES - 1);
      adv       = 1'b0;
      wr_inc    = 1'b0;
      latch     = 1'b0;
      retry_inc = 1'b0;
      retry_clr = 1'b0;
    end
  end

  // pin-level outputs decoded from the upcoming state, then registered
  always_comb begin
    pwdn_nxt  = (state_nxt == S_PWDN);
    crstn_nxt = !((state_nxt == S_PWDN) || (state_nxt == S_RST));
    start_nxt = (state_nxt == S_REQ);
    done_nxt  = (state_nxt == S_DONE);
    err_nxt   = (state_nxt == S_ERR);
  end

  // registered outputs: glitch-free, since sccb_start crosses domains
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      cam_pwdn   <= 1'b1;
      cam_rstn   <= 1'b0;
      sccb_start <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      cam_pwdn   <= pwdn_nxt;
      cam_rstn   <= crstn_nxt;
      sccb_start <= start_nxt;
      init_done  <= done_nxt;
      init_err   <= err_nxt;
    end
  end

  // table index, write count, transaction payload and retry count
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      cfg_addr  <= '0;
      reg_count <= '0;
      sccb_data <= '0;
      sccb_wr   <= 2'b00;
      retry_q   <= 2'd0;
    end else if (dbun) begin
      cfg_addr  <= '0;
      reg_count <= '0;
      sccb_data <= '0;
      sccb_wr   <= 2'b00;
      retry_q   <= 2'd0;
    end else begin
      if (latch) begin
        sccb_data <= {8'h00, cfg_data};
        sccb_wr   <= 2'b01;
      end
      if (state_nxt == S_ERR) sccb_wr <= 2'b00;
      // cfg_addr saturates at the last entry instead of wrapping
      if (adv && !last) cfg_addr <= cfg_addr + 1'b1;
      if (wr_inc) reg_count <= reg_count + 1'b1;
      if (retry_clr)      retry_q <= 2'd0;
      else if (retry_inc) retry_q <= retry_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq with short timing parameters and a 4-entry table.
module tb_cam_init_seq;
  localparam int AW = 2;

  logic          cam_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dbun = 1'b0;
  logic [AW-1:0] cfg_addr;
  logic [23:0]   cfg_data = 24'h0;
  logic          sccb_start;
  logic [1:0]    sccb_wr;
  logic [31:0]   sccb_data;
  logic          sccb_busy = 1'b0;
  logic          cam_pwdn, cam_rstn, init_done, init_err;
  logic [AW:0]   reg_count;
`ifdef CAM_INIT_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  logic [23:0]   tbl [0:3];
  int            errors = 0;
  int            checks = 0;
  bit            busy_en = 1'b0;
  logic          start_q = 1'b0;
  logic [31:0]   wlog [$];

  cam_init_seq #(
    .PWDN_CYCLES(16), .RST_CYCLES(32), .SETTLE_CYCLES(8),
    .ADDR_W(AW), .TIMEOUT_CYCLES(100)
  ) dut (
    .cam_clk(cam_clk), .rstn(rstn), .dbun(dbun),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sccb_start(sccb_start), .sccb_wr(sccb_wr), .sccb_data(sccb_data),
    .sccb_busy(sccb_busy),
    .cam_pwdn(cam_pwdn), .cam_rstn(cam_rstn),
    .init_done(init_done), .init_err(init_err),
`ifdef CAM_INIT_RETRY_EN
    .retry_cnt(retry_cnt),
`endif
    .reg_count(reg_count)
  );

  always #5 cam_clk = ~cam_clk;

  // synchronous table ROM: data valid one cycle after the address
  always @(posedge cam_clk) cfg_data <= tbl[cfg_addr];

  // SCCB master model: busy 5 cycles after start, held for 40 cycles
  always begin
    @(negedge cam_clk);
    if (busy_en && sccb_start && !sccb_busy) begin
      repeat (5) @(negedge cam_clk);
      sccb_busy = 1'b1;
      repeat (40) @(negedge cam_clk);
      sccb_busy = 1'b0;
    end
  end

  // log the payload at every rising edge of sccb_start
  always @(negedge cam_clk) begin
    if (sccb_start && !start_q) wlog.push_back(sccb_data);
    start_q = sccb_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge cam_clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!init_done && k < lim) begin
      @(posedge cam_clk); #1;
      k++;
    end
    chk(tag, {31'b0, init_done}, 32'd1);
  endtask

  // hold dbun for one edge, load a new table, then release at the next negedge
  task automatic restart(input logic [23:0] t0, t1, t2, t3);
    @(negedge cam_clk);
    dbun = 1'b1;
    tbl[0] = t0; tbl[1] = t1; tbl[2] = t2; tbl[3] = t3;
    @(posedge cam_clk); #1;
    wlog.delete();
    @(negedge cam_clk);
    dbun = 1'b0;
  endtask

  initial begin
    tbl[0] = 24'h300812; tbl[1] = 24'h310363; tbl[2] = 24'hFFFFFF; tbl[3] = 24'h000000;
    #23;
    chk("rst_ctl", {27'b0, cam_pwdn, cam_rstn, sccb_start, init_done, init_err}, 32'h10);
    chk("rst_data", sccb_data, 32'h0);
    chk("rst_idx", {25'b0, sccb_wr, cfg_addr, reg_count}, 32'h0);

    // power-up release and three-entry table
    @(negedge cam_clk);
    rstn = 1'b1;
    busy_en = 1'b1;
    edges(15); chk("pwdn_hold", {31'b0, cam_pwdn}, 32'd1);
    edges(1);  chk("pwdn_fall", {30'b0, cam_pwdn, cam_rstn}, 32'd0);
    edges(31); chk("rstn_hold", {31'b0, cam_rstn}, 32'd0);
    edges(1);  chk("rstn_rise", {31'b0, cam_rstn}, 32'd1);
    edges(9);  chk("start_pre", {31'b0, sccb_start}, 32'd0);
    edges(1);  chk("start_rise", {31'b0, sccb_start}, 32'd1);
    chk("data0", sccb_data, 32'h00300812);
    chk("wr0", {30'b0, sccb_wr}, 32'd1);
    wait_done("done_tbl3", 2000);
    chk("tbl3_nwr", wlog.size(), 32'd2);
    chk("data1", (wlog.size() > 1) ? wlog[1] : 32'hDEAD_BEEF, 32'h00310363);
    chk("tbl3_cnt", {29'b0, reg_count}, 32'd2);
    chk("tbl3_err", {31'b0, init_err}, 32'd0);
    chk("tbl3_addr", {30'b0, cfg_addr}, 32'd2);

    // delay entry: 2048 cycles between fetch of entry 0 (edge 56) and entry 1
    restart(24'hFFF002, 24'hFFFFFF, 24'h000000, 24'h000000);
    edges(2103); chk("dly_addr0", {30'b0, cfg_addr}, 32'd0);
    edges(1);    chk("dly_addr1", {30'b0, cfg_addr}, 32'd1);
    wait_done("done_dly", 200);
    chk("dly_nwr", wlog.size(), 32'd0);
    chk("dly_cnt", {29'b0, reg_count}, 32'd0);

    // handshake timeout with busy held low
    busy_en = 1'b0;
    restart(24'h123456, 24'hFFFFFF, 24'h000000, 24'h000000);
    edges(58); chk("to_req", {31'b0, sccb_start}, 32'd1);
`ifdef CAM_INIT_RETRY_EN
    edges(402); chk("to_pre", {31'b0, init_err}, 32'd0);
    edges(1);   chk("to_err", {30'b0, init_err, sccb_start}, 32'b10);
    chk("to_starts", wlog.size(), 32'd4);
    chk("to_retry", {30'b0, retry_cnt}, 32'd3);
`else
    edges(99); chk("to_pre", {30'b0, init_err, sccb_start}, 32'b01);
    edges(1);  chk("to_err", {30'b0, init_err, sccb_start}, 32'b10);
    chk("to_starts", wlog.size(), 32'd1);
`endif
    chk("to_wr", {30'b0, sccb_wr}, 32'd0);

    // dbun while the second write is in WAIT with busy high
    busy_en = 1'b1;
    restart(24'h300812, 24'h310363, 24'hFFFFFF, 24'h000000);
    begin
      int k = 0;
      while (!(wlog.size() == 2 && sccb_busy) && k < 1000) begin
        @(posedge cam_clk); #1;
        k++;
      end
      chk("dbw_seen", {31'b0, sccb_busy}, 32'd1);
    end
    edges(5);
    chk("dbw_wait", {28'b0, reg_count, sccb_start}, {28'b0, 3'd1, 1'b0});
    @(negedge cam_clk);
    dbun = 1'b1;
    @(posedge cam_clk); #1;
    chk("dbw_pins", {30'b0, cam_pwdn, cam_rstn}, 32'b10);
    chk("dbw_clr", {27'b0, reg_count, cfg_addr}, 32'd0);
    wlog.delete();
    @(negedge cam_clk);
    dbun = 1'b0;
    wait_done("done_dbw", 3000);
    chk("dbw_first", (wlog.size() > 0) ? wlog[0] : 32'hDEAD_BEEF, 32'h00300812);
    chk("dbw_cnt", {29'b0, reg_count}, 32'd2);

    // full table without an end marker
    restart(24'h123401, 24'h123402, 24'h123403, 24'h123404);
    wait_done("done_full", 3000);
    chk("full_nwr", wlog.size(), 32'd4);
    chk("full_last", (wlog.size() > 3) ? wlog[3] : 32'hDEAD_BEEF, 32'h00123404);
    chk("full_addr", {30'b0, cfg_addr}, 32'd3);
    chk("full_cnt", {29'b0, reg_count}, 32'd4);

    // asynchronous reset mid-sequence
    restart(24'h300812, 24'hFFFFFF, 24'h000000, 24'h000000);
    edges(30);
    chk("arst_pre", {30'b0, cam_pwdn, cam_rstn}, 32'b00);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pins", {30'b0, cam_pwdn, cam_rstn}, 32'b10);
    chk("arst_idx", {27'b0, reg_count, cfg_addr}, 32'd0);
    #20;
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
